// File: rtl/ddr_bridge_pkg.sv
// rtl/ddr_bridge_pkg.sv - shared types and constants for the DDR line bridge
`timescale 1ns/1ps
package ddr_bridge_pkg;

    localparam int BEAT_W         = 64;
    localparam int LINE_W         = 512;
    localparam int BEATS_PER_LINE = 8;
    localparam int CNT_W          = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/ddr_line_bridge.sv
// rtl/ddr_line_bridge.sv - splits 512-bit line requests into 64-bit beats and reassembles reads
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   ddr_*                   single-cycle line request from the core, read line,
//                           done pulse and ready level back to the core
//   mem_req_*               beat request channel (valid/ready) to memory
//   mem_resp_*              in-order beat responses (read data or write ack)
//   perf_*                  line/stall counters, present only with DDR_BRIDGE_PERF_EN
`timescale 1ns/1ps
module ddr_line_bridge
    import ddr_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ddr_chip_enable,
    input  logic [63:0]           ddr_index,
    input  logic                  ddr_write_enable,
    input  logic                  ddr_burst_mode,
    input  logic [LINE_W-1:0]     ddr_write_data,
    output logic [LINE_W-1:0]     ddr_read_data,
    output logic                  ddr_operation_done,
    output logic                  ddr_ready,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_write,
    output logic [BEAT_W-1:0]     mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [BEAT_W-1:0]     mem_resp_rdata
`ifdef DDR_BRIDGE_PERF_EN
    ,
    output logic [31:0]           perf_rd_lines,
    output logic [31:0]           perf_wr_lines,
    output logic [31:0]           perf_stall_cycles
`endif
);

    state_t state, state_next;

    logic [63:0]       idx_q;
    logic              wr_q;
    logic              burst_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  recv_q;
    logic [CNT_W-1:0]  outst_q;

    logic [CNT_W-1:0]  total;
    logic              xfer;
    logic              resp_in;
    logic              last_resp;
    logic [63:0]       word_idx;
    logic [66:0]       byte_addr;
    logic              unused_addr_bits;

    assign total     = burst_q ? CNT_W'(BEATS_PER_LINE) : CNT_ONE;
    assign xfer      = mem_req_valid && mem_req_ready;
    // Responses outside BUSY are stray (e.g. late after a reset) and are dropped.
    assign resp_in   = (state == BUSY) && mem_resp_valid;
    assign last_resp = resp_in && (recv_q == total - CNT_ONE);

    // Adding the beat number to the word index before the 3-bit shift gives the
    // same low ADDR_WIDTH bits as {index,3'b000} + 8*k, so truncation wraps naturally.
    assign word_idx  = (burst_q ? {idx_q[63:3], 3'b000} : idx_q) + {60'b0, issued_q};
    assign byte_addr = {word_idx, 3'b000};
    assign unused_addr_bits = ^byte_addr;

    assign mem_req_valid = (state == BUSY) && (issued_q < total) &&
                           (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign mem_req_addr  = byte_addr[ADDR_WIDTH-1:0];
    assign mem_req_write = wr_q;
    assign ddr_read_data = rdata_q;

    // Single beats always use slot 0, which is where issued_q sits for them.
    always_comb begin
        mem_req_wdata = wdata_q[BEAT_W-1:0];
        for (int k = 0; k < BEATS_PER_LINE; k++) begin
            if (issued_q[2:0] == 3'(k)) begin
                mem_req_wdata = wdata_q[k*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        ddr_ready          = 1'b0;
        ddr_operation_done = 1'b0;
        case (state)
            IDLE: begin
                ddr_ready = 1'b1;
                if (ddr_chip_enable) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ddr_operation_done = 1'b1;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            wr_q     <= 1'b0;
            burst_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            outst_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ddr_chip_enable) begin
                        idx_q    <= ddr_index;
                        wr_q     <= ddr_write_enable;
                        burst_q  <= ddr_burst_mode;
                        wdata_q  <= ddr_write_data;
                        issued_q <= '0;
                        recv_q   <= '0;
                        outst_q  <= '0;
                        // Cleared so single reads return zero above the first beat.
                        if (!ddr_write_enable) begin
                            rdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        issued_q <= issued_q + CNT_ONE;
                    end
                    case ({xfer, resp_in})
                        2'b10:   outst_q <= outst_q + CNT_ONE;
                        2'b01:   outst_q <= outst_q - CNT_ONE;
                        default: outst_q <= outst_q;
                    endcase
                    if (resp_in) begin
                        recv_q <= recv_q + CNT_ONE;
                        if (!wr_q) begin
                            for (int k = 0; k < BEATS_PER_LINE; k++) begin
                                if (recv_q[2:0] == 3'(k)) begin
                                    rdata_q[k*BEAT_W +: BEAT_W] <= mem_resp_rdata;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DDR_BRIDGE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_rd_lines     <= '0;
            perf_wr_lines     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (state == DONE && !wr_q) begin
                perf_rd_lines <= perf_rd_lines + 32'd1;
            end
            if (state == DONE && wr_q) begin
                perf_wr_lines <= perf_wr_lines + 32'd1;
            end
            if (mem_req_valid && !mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ddr_line_bridge.md
Name: ddr_line_bridge

Overview:
- Sits directly downstream of the core's DDR port.
- Consumes the single-cycle line request (chip enable, index, write enable, burst mode, 512-bit write data) and splits it into 64-bit beat transactions on a simple valid/ready memory interface.
- Collects the beat responses, reassembles the 512-bit read line, and returns it with a one-cycle operation-done pulse and a ready level.
- Supports up to MAX_OUTSTANDING in-flight beats.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on mem_req_addr.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered beats; legal range 1..8.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- ddr_chip_enable  in  1  one-cycle request strobe from the core.
- ddr_index  in  64  64-bit-word index; in burst mode the low 3 bits are ignored, giving a line-aligned address.
- ddr_write_enable  in  1  1 = write, 0 = read.
- ddr_burst_mode  in  1  1 = 8-beat line; 0 = single 64-bit beat.
- ddr_write_data  in  512  line write data; beat k uses bits [64k+63:64k].
- ddr_read_data  out  512  assembled read line.
- ddr_operation_done  out  1  one-cycle completion pulse.
- ddr_ready  out  1  block can accept a request.
- mem_req_valid  out  1  beat request valid.
- mem_req_ready  in  1  memory accepts the beat.
- mem_req_addr  out  ADDR_WIDTH  byte address, equal to {index, 3'b000} + 8·k, truncated to ADDR_WIDTH.
- mem_req_write  out  1  beat is a write.
- mem_req_wdata  out  64  beat write data.
- mem_resp_valid  in  1  in-order response: read data or write acknowledge.
- mem_resp_rdata  in  64  beat read data.

Behaviour:
- Reset values: ddr_read_data=0, ddr_operation_done=0, ddr_ready=1, mem_req_valid=0, mem_req_addr=0, mem_req_write=0, mem_req_wdata=0. FSM=IDLE; all counters=0.
- FSM IDLE:
  - ddr_ready=1.
  - When ddr_chip_enable=1, latch index, write enable, burst mode and write data. Set total beats N=8 for burst, 1 otherwise. Go to BUSY.
  - On a read accept, clear ddr_read_data to 0, so single reads return zero in bits [511:64].
- FSM BUSY:
  - ddr_ready=0.
  - mem_req_valid=1 while issued<N and outstanding<MAX_OUTSTANDING.
  - A beat transfers when mem_req_valid && mem_req_ready; then issued++ and outstanding++.
  - Each mem_resp_valid does recv++ and outstanding--. On a read, it also writes ddr_read_data[64·recv +: 64].
  - A transfer and a response in the same cycle leave outstanding unchanged.
  - When the response with recv==N-1 arrives, go to DONE.
- FSM DONE:
  - ddr_operation_done=1 for exactly this cycle; ddr_ready=0.
  - Next cycle go to IDLE.
- Request outputs stay stable while mem_req_valid=1 and mem_req_ready=0.
- ddr_read_data holds its value from DONE until the next read accept. Writes never modify it.
- ddr_chip_enable while ddr_ready=0 is ignored; no queueing.
- mem_resp_valid in IDLE or DONE is dropped.
- Latency with ideal memory (ready always 1, response one cycle after a request), accept at cycle T:
  - burst beats issued T+1..T+8, responses T+2..T+9, done T+10, ddr_ready=1 at T+11;
  - single beat: done at T+3.
  - With MAX_OUTSTANDING=1, each burst beat costs 2 cycles.
- Beat address wraps modulo 2^ADDR_WIDTH.
- Reset asserted mid-operation aborts immediately with no done pulse. Late responses are then dropped in IDLE.

Optional Feature:
- Macro DDR_BRIDGE_PERF_EN. When defined, adds three 32-bit outputs, cleared by reset and wrapping on overflow:
  - perf_rd_lines: increments on DONE for a read.
  - perf_wr_lines: increments on DONE for a write.
  - perf_stall_cycles: increments each cycle with mem_req_valid=1 and mem_req_ready=0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package ddr_bridge_pkg contains:
  - state enum {IDLE, BUSY, DONE};
  - constants BEAT_W=64, LINE_W=512, BEATS_PER_LINE=8;
  - beat-count width 4.
- No sub-module; the FSM, the three counters and the line register fit in one module.

Test Plan:
- Burst read at index 0x1234 (line base 0x1230), ideal memory, rdata = 0x100+k: beat addresses 0x9180..0x91B8 step 8; done at T+10; ddr_read_data[64k+:64] = 0x100+k; ddr_ready high at T+11.
- Single write at index 0x5, wdata[63:0]=0xDEADBEEF: exactly one beat, addr 0x28, write=1, wdata 0xDEADBEEF; done at T+3; ddr_read_data unchanged.
- Burst read with MAX_OUTSTANDING=2, memory latency 5: outstanding never exceeds 2; the data order is preserved.
- Burst read with mem_req_ready low for 3 cycles on beat 2: addr/wdata held stable; 8 beats total; done asserted once.
- Second ddr_chip_enable during BUSY: ignored, exactly one done; a spurious mem_resp_valid in IDLE leaves ddr_read_data unchanged.
- reset_n low at beat 4 of a burst read: outputs at reset values; ddr_ready=1 with no done pulse; a following single read of 0x77 completes correctly. With DDR_BRIDGE_PERF_EN, perf_rd_lines=1 after that read.
